axi_pcie_rq_tag_mgr: RTL and testbench

- Tag allocator and outstanding-read tracker for the PCIe AXI Requester path.
- Sits directly upstream of the AXI4S RQ request generator: it hands out a free tag for each memory-read TLP before the TLP is issued on RQ.
- Consumes decoded RC completion descriptors and returns a tag to the free pool once all requested dwords have arrived.
- Provides flow control (no free tag means no request) and error indications for unexpected or oversized completions.

---
 rtl/axi_pcie_rq_tag_mgr_if.sv | 31 +++
 rtl/axi_pcie_rq_tag_mgr.sv | 175 +++++++++++++++++
 tb/tb_axi_pcie_rq_tag_mgr.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pcie_rq_tag_mgr_if.sv
// Request/completion bundle between the RQ requester and the tag manager.
// The master drives requests and completion descriptors; the slave is the tag manager.
interface axi_pcie_rq_tag_mgr_if #(
    parameter int unsigned TAG_WIDTH = 8
);
    logic                 req_vld;
    logic [10:0]          req_len;
    logic                 req_rdy;
    logic [TAG_WIDTH-1:0] alloc_tag;

    logic                 cpl_vld;
    logic [TAG_WIDTH-1:0] cpl_tag;
    logic [10:0]          cpl_len;
    logic                 cpl_err;
    logic                 cpl_unexp;
    logic                 cpl_overrun;

    logic [TAG_WIDTH:0]   free_cnt;
    logic                 timeout_vld;
    logic [TAG_WIDTH-1:0] timeout_tag;

    modport master (
        output req_vld, req_len, cpl_vld, cpl_tag, cpl_len, cpl_err,
        input  req_rdy, alloc_tag, cpl_unexp, cpl_overrun, free_cnt, timeout_vld, timeout_tag
    );

    modport slave (
        input  req_vld, req_len, cpl_vld, cpl_tag, cpl_len, cpl_err,
        output req_rdy, alloc_tag, cpl_unexp, cpl_overrun, free_cnt, timeout_vld, timeout_tag
    );
endinterface

// File: rtl/axi_pcie_rq_tag_mgr.sv
// Tag allocator and outstanding-read tracker for the PCIe AXI requester path.
// Define AXI_PCIE_RQ_TAG_TIMEOUT_EN to add the round-robin completion-timeout scanner.
module axi_pcie_rq_tag_mgr #(
    parameter int unsigned TAG_WIDTH      = 8,
    parameter int unsigned TAGS           = 64,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    axi_pcie_rq_tag_mgr_if.slave tag_if
);
    localparam int unsigned IdxW = $clog2(TAGS);
    localparam logic [TAG_WIDTH:0] CntInit = TAGS[TAG_WIDTH:0];

    typedef logic [IdxW-1:0]      idx_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    function automatic idx_t wrap_inc(idx_t v);
        return (v == idx_t'(TAGS - 1)) ? '0 : v + idx_t'(1);
    endfunction

    function automatic logic [10:0] len_dec(logic [10:0] len);
        return (len == 11'd0) ? 11'd1024 : len;
    endfunction

    tag_t               fifo_q [TAGS];
    idx_t               head_q, tail_q;
    logic [TAG_WIDTH:0] cnt_q, cnt_d;
    logic               req_rdy_q;
    logic [TAGS-1:0]    busy_q;
    logic [10:0]        rem_q  [TAGS];
    logic               unexp_q, overrun_q;

    logic        pop, push;
    idx_t        pop_idx, cpl_idx;
    tag_t        push_tag;
    logic        cpl_hit, cpl_rel, cpl_part, cpl_over, cpl_unexp;
    logic [10:0] cpl_len, cpl_rem;
    logic        to_hit;
    tag_t        to_tag;

    always_comb begin
        pop     = tag_if.req_vld && req_rdy_q;
        pop_idx = fifo_q[head_q][IdxW-1:0];
        cpl_idx = tag_if.cpl_tag[IdxW-1:0];
        cpl_len = len_dec(tag_if.cpl_len);
        cpl_rem = rem_q[cpl_idx];
        // Tags beyond TAGS-1 are never busy, so they fall into the unexpected path.
        cpl_hit   = tag_if.cpl_vld && (32'(tag_if.cpl_tag) < TAGS) && busy_q[cpl_idx];
        cpl_unexp = tag_if.cpl_vld && !cpl_hit;
        cpl_over  = cpl_hit && !tag_if.cpl_err && (cpl_len > cpl_rem);
        cpl_rel   = cpl_hit && (tag_if.cpl_err || (cpl_len >= cpl_rem));
        cpl_part  = cpl_hit && !cpl_rel;
        push      = cpl_rel || to_hit;
        push_tag  = cpl_rel ? tag_if.cpl_tag : to_tag;

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < TAGS; i++) begin
                fifo_q[i] <= tag_t'(i);
                rem_q[i]  <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= CntInit;
            req_rdy_q <= 1'b0;
            busy_q    <= '0;
            unexp_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (pop) begin
                busy_q[pop_idx] <= 1'b1;
                rem_q[pop_idx]  <= len_dec(tag_if.req_len);
                head_q          <= wrap_inc(head_q);
            end
            if (cpl_part) begin
                rem_q[cpl_idx] <= cpl_rem - cpl_len;
            end
            if (cpl_rel) begin
                busy_q[cpl_idx] <= 1'b0;
            end
            if (to_hit) begin
                busy_q[to_tag[IdxW-1:0]] <= 1'b0;
            end
            if (push) begin
                fifo_q[tail_q] <= push_tag;
                tail_q         <= wrap_inc(tail_q);
            end
            cnt_q     <= cnt_d;
            req_rdy_q <= (cnt_d != '0);
            unexp_q   <= cpl_unexp;
            overrun_q <= cpl_over;
        end
    end

    assign tag_if.req_rdy     = req_rdy_q;
    assign tag_if.alloc_tag   = fifo_q[head_q];
    assign tag_if.free_cnt    = cnt_q;
    assign tag_if.cpl_unexp   = unexp_q;
    assign tag_if.cpl_overrun = overrun_q;

`ifdef AXI_PCIE_RQ_TAG_TIMEOUT_EN
    logic [31:0] ts_q;
    logic [31:0] stamp_q [TAGS];
    idx_t        scan_q;
    logic        to_vld_q;
    tag_t        to_tag_q;

    // Completion releases own the single free-list push slot; the scanner stalls behind them.
    assign to_hit = !cpl_rel && busy_q[scan_q] &&
                    ((ts_q - stamp_q[scan_q]) >= 32'(TIMEOUT_CYCLES));
    assign to_tag = tag_t'(scan_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < TAGS; i++) begin
                stamp_q[i] <= '0;
            end
            ts_q     <= '0;
            scan_q   <= '0;
            to_vld_q <= 1'b0;
            to_tag_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (pop) begin
                stamp_q[pop_idx] <= ts_q;
            end
            if (!cpl_rel) begin
                scan_q <= wrap_inc(scan_q);
            end
            to_vld_q <= to_hit;
            if (to_hit) begin
                to_tag_q <= to_tag;
            end
        end
    end

    assign tag_if.timeout_vld = to_vld_q;
    assign tag_if.timeout_tag = to_tag_q;
`else
    assign to_hit             = 1'b0;
    assign to_tag             = '0;
    assign tag_if.timeout_vld = 1'b0;
    assign tag_if.timeout_tag = '0;
`endif

`ifndef SYNTHESIS
    function automatic idx_t ring_idx(idx_t base, int unsigned off);
        return idx_t'((32'(base) + off) % TAGS);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (TAGS >= 2 && TIMEOUT_CYCLES > 0) else $error("illegal tag manager parameters");
            assert (cnt_q <= CntInit) else $error("free count exceeds TAGS");
            if (push) begin
                for (int unsigned i = 0; i < TAGS; i++) begin
                    if (i < 32'(cnt_q)) begin
                        assert (fifo_q[ring_idx(head_q, i)] != push_tag)
                            else $error("tag %0d pushed while already free", push_tag);
                    end
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_axi_pcie_rq_tag_mgr.sv
// Directed bench for axi_pcie_rq_tag_mgr: allocation, completion, error, reset and timeout cases.
module tb_axi_pcie_rq_tag_mgr;
    localparam int unsigned TW = 8;
    localparam int unsigned NT = 64;
    localparam int unsigned TO = 100;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axi_pcie_rq_tag_mgr_if #(.TAG_WIDTH(TW)) bus ();

    axi_pcie_rq_tag_mgr #(
        .TAG_WIDTH      (TW),
        .TAGS           (NT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tag_if (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_vld = 1'b0;
        bus.req_len = 11'd0;
        bus.cpl_vld = 1'b0;
        bus.cpl_tag = '0;
        bus.cpl_len = 11'd0;
        bus.cpl_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic request(input logic [10:0] len);
        bus.req_vld = 1'b1;
        bus.req_len = len;
        tick();
        bus.req_vld = 1'b0;
    endtask

    task automatic complete(input int tag, input logic [10:0] len, input logic err);
        bus.cpl_vld = 1'b1;
        bus.cpl_tag = TW'(tag);
        bus.cpl_len = len;
        bus.cpl_err = err;
        tick();
        bus.cpl_vld = 1'b0;
        bus.cpl_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int to_cnt;
        logic [TW-1:0] seen_tag;

        // Reset values
        rst_n = 1'b0;
        clear_inputs();
        #7;
        check_eq("rst_free_cnt", bus.free_cnt, 64);
        check_eq("rst_req_rdy", bus.req_rdy, 0);
        check_eq("rst_alloc_tag", bus.alloc_tag, 0);
        check_eq("rst_unexp", bus.cpl_unexp, 0);
        check_eq("rst_overrun", bus.cpl_overrun, 0);
        check_eq("rst_timeout_vld", bus.timeout_vld, 0);
        check_eq("rst_timeout_tag", bus.timeout_tag, 0);
        #1 rst_n = 1'b1;
        tick();
        check_eq("rdy_after_rst", bus.req_rdy, 1);

        // Three back-to-back grants
        for (int k = 0; k < 3; k++) begin
            bus.req_vld = 1'b1;
            bus.req_len = 11'd4;
            #1;
            check_eq("b2b_alloc_tag", bus.alloc_tag, k);
            tick();
        end
        bus.req_vld = 1'b0;
        check_eq("b2b_free_cnt", bus.free_cnt, 61);
        check_eq("b2b_rdy", bus.req_rdy, 1);

        // Split completion 16 + 16 on a 32-dword read
        do_reset();
        request(11'd32);
        check_eq("split_free_after_alloc", bus.free_cnt, 63);
        complete(0, 11'd16, 1'b0);
        check_eq("split_free_partial", bus.free_cnt, 63);
        check_eq("split_unexp_partial", bus.cpl_unexp, 0);
        complete(0, 11'd16, 1'b0);
        check_eq("split_free_done", bus.free_cnt, 64);
        check_eq("split_unexp_done", bus.cpl_unexp, 0);
        check_eq("split_overrun_done", bus.cpl_overrun, 0);
        complete(0, 11'd1, 1'b0);
        check_eq("split_released_unexp", bus.cpl_unexp, 1);

        // Exhaust the pool, then free tag 5 with the requester holding REQ_VLD
        do_reset();
        bus.req_vld = 1'b1;
        bus.req_len = 11'd0;
        for (int k = 0; k < NT; k++) begin
            #1;
            check_eq("full_alloc_tag", bus.alloc_tag, k);
            tick();
        end
        tick();
        check_eq("full_rdy", bus.req_rdy, 0);
        check_eq("full_free_cnt", bus.free_cnt, 0);
        bus.cpl_vld = 1'b1;
        bus.cpl_tag = 8'd5;
        bus.cpl_len = 11'd0;
        tick();
        bus.cpl_vld = 1'b0;
        check_eq("refill_rdy", bus.req_rdy, 1);
        check_eq("refill_alloc_tag", bus.alloc_tag, 5);
        check_eq("refill_free_cnt", bus.free_cnt, 1);
        tick();
        bus.req_vld = 1'b0;
        check_eq("regrant_free_cnt", bus.free_cnt, 0);
        check_eq("regrant_rdy", bus.req_rdy, 0);

        // Unexpected and overrun completions
        do_reset();
        complete(10, 11'd4, 1'b0);
        check_eq("unexp_pulse", bus.cpl_unexp, 1);
        check_eq("unexp_free_cnt", bus.free_cnt, 64);
        tick();
        check_eq("unexp_pulse_end", bus.cpl_unexp, 0);
        for (int k = 0; k < 4; k++) request(11'd8);
        check_eq("ovr_free_before", bus.free_cnt, 60);
        complete(3, 11'd12, 1'b0);
        check_eq("ovr_pulse", bus.cpl_overrun, 1);
        check_eq("ovr_no_unexp", bus.cpl_unexp, 0);
        check_eq("ovr_free_after", bus.free_cnt, 61);
        tick();
        check_eq("ovr_pulse_end", bus.cpl_overrun, 0);
        complete(3, 11'd1, 1'b0);
        check_eq("ovr_tag_freed", bus.cpl_unexp, 1);

        // Grant plus full completion in one cycle; aborted tag; same-cycle grant/complete
        bus.req_vld = 1'b1;
        bus.req_len = 11'd8;
        bus.cpl_vld = 1'b1;
        bus.cpl_tag = 8'd1;
        bus.cpl_len = 11'd8;
        #1;
        check_eq("pp_alloc_tag", bus.alloc_tag, 4);
        tick();
        clear_inputs();
        check_eq("pp_free_cnt", bus.free_cnt, 61);
        complete(2, 11'd2, 1'b1);
        check_eq("err_free_cnt", bus.free_cnt, 62);
        check_eq("err_no_unexp", bus.cpl_unexp, 0);
        check_eq("err_no_overrun", bus.cpl_overrun, 0);
        complete(2, 11'd1, 1'b0);
        check_eq("err_tag_freed", bus.cpl_unexp, 1);
        bus.req_vld = 1'b1;
        bus.req_len = 11'd8;
        bus.cpl_vld = 1'b1;
        bus.cpl_tag = 8'd5;
        bus.cpl_len = 11'd8;
        #1;
        check_eq("same_alloc_tag", bus.alloc_tag, 5);
        tick();
        clear_inputs();
        check_eq("same_unexp", bus.cpl_unexp, 1);
        check_eq("same_free_cnt", bus.free_cnt, 61);

        // Reset with 20 tags outstanding
        do_reset();
        bus.req_vld = 1'b1;
        bus.req_len = 11'd4;
        for (int k = 0; k < 20; k++) tick();
        bus.req_vld = 1'b0;
        check_eq("mid_free_before", bus.free_cnt, 44);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_free_cnt", bus.free_cnt, 64);
        check_eq("mid_rst_rdy", bus.req_rdy, 0);
        check_eq("mid_rst_head", bus.alloc_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("mid_rdy_after", bus.req_rdy, 1);
        complete(7, 11'd4, 1'b0);
        check_eq("late_cpl_unexp", bus.cpl_unexp, 1);

        // Uncompleted tag: expires with the timeout build, never reported otherwise
        do_reset();
        request(11'd4);
        seen     = 0;
        to_cnt   = 0;
        seen_tag = '0;
        for (int c = 0; c < int'(TO + NT + 2); c++) begin
            tick();
            if (bus.timeout_vld === 1'b1) begin
                to_cnt++;
                if (seen == 0) begin
                    seen     = 1;
                    seen_tag = bus.timeout_tag;
                end
            end
        end
`ifdef AXI_PCIE_RQ_TAG_TIMEOUT_EN
        check_eq("to_seen", seen, 1);
        check_eq("to_pulse_count", to_cnt, 1);
        check_eq("to_tag", seen_tag, 0);
        check_eq("to_free_cnt", bus.free_cnt, 64);
`else
        check_eq("to_disabled_vld", to_cnt, 0);
        check_eq("to_disabled_tag", bus.timeout_tag, 0);
        check_eq("to_disabled_free", bus.free_cnt, 63);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
